i2c_bus_mon: RTL and testbench

- Multi-channel, parametrised I2C bus monitor for the SDA/SCL interface of the DUT.
- Per channel it synchronises and deglitches SCL and SDA, and detects START, repeated START and STOP.
- It captures each byte with its ACK bit and flags SCL-low timeouts.
- It feeds the TG/Glitch assertion checkers and can also be synthesised as an on-chip bus observer.

---
 rtl/i2c_mon_pkg.sv | 13 +
 rtl/i2c_deglitch.sv | 48 ++++
 rtl/i2c_bus_mon.sv | 163 ++++++++++++++++
 tb/tb_i2c_bus_mon.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_mon_pkg.sv
// Shared definitions for the I2C bus monitor: channel FSM encoding and bus levels.
package i2c_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic BUS_IDLE = 1'b1;
   localparam logic ACK_LVL  = 1'b0;

endpackage

// File: rtl/i2c_deglitch.sv
// One I2C line: two-flop synchroniser followed by a FILT_LEN-cycle stability filter
// that reports aborted transitions as a one-cycle glitch pulse.
module i2c_deglitch
   import i2c_mon_pkg::*;
#(
   parameter int FILT_LEN = 3,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt,
   output logic glitch
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // The counter value CNT_LAST plus the current differing cycle makes FILT_LEN stable cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= BUS_IDLE;
         sync2  <= BUS_IDLE;
         filt   <= BUS_IDLE;
         cnt    <= '0;
         glitch <= 1'b0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         glitch <= 1'b0;
         if (sync2 != filt) begin
            if (cnt == CNT_LAST) begin
               filt <= sync2;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else if (cnt != '0) begin
            cnt    <= '0;
            glitch <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_bus_mon.sv
// Multi-channel I2C bus monitor: filtered lines, START/STOP detection, byte+ACK capture
// and SCL-low timeout per channel; channels share nothing but the clock and reset.
module i2c_bus_mon
   import i2c_mon_pkg::*;
#(
   parameter int NCH      = 1,
   parameter int FILT_LEN = 3,
   parameter int CNT_W    = 4,
   parameter int TO_CYC   = 1024,
   parameter int TO_W     = 11
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [NCH-1:0]   EN,
   input  logic [NCH-1:0]   SCL_IN,
   input  logic [NCH-1:0]   SDA_IN,
   output logic [NCH-1:0]   SCL_F,
   output logic [NCH-1:0]   SDA_F,
   output logic [NCH-1:0]   START_P,
   output logic [NCH-1:0]   STOP_P,
   output logic [NCH-1:0]   BYTE_VLD,
   output logic [8*NCH-1:0] BYTE_DATA,
   output logic [NCH-1:0]   BYTE_ACK,
   output logic [NCH-1:0]   BYTE_FIRST,
   output logic [NCH-1:0]   GLITCH_P,
   output logic [NCH-1:0]   TIMEOUT_P,
   output logic [NCH-1:0]   BUSY
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic            scl_f, sda_f, scl_glitch, sda_glitch;
      logic            scl_q, sda_q;
      logic            start_det, stop_det, sample;
      state_t          state, state_nxt;
      logic [3:0]      bitcnt, bitcnt_nxt;
      logic [7:0]      shreg, shreg_nxt;
      logic [7:0]      data, data_nxt;
      logic            first, first_nxt;
      logic            ack, ack_nxt;
      logic            bfirst, bfirst_nxt;
      logic            start_p, start_nxt;
      logic            stop_p, stop_nxt;
      logic            vld, vld_nxt;
      logic            to_p, to_nxt;
      logic [TO_W-1:0] to_cnt, to_cnt_nxt;

      i2c_deglitch #(.FILT_LEN(FILT_LEN), .CNT_W(CNT_W)) u_scl (
         .clk(CLK), .rst(RST), .raw(SCL_IN[i]), .filt(scl_f), .glitch(scl_glitch)
      );

      i2c_deglitch #(.FILT_LEN(FILT_LEN), .CNT_W(CNT_W)) u_sda (
         .clk(CLK), .rst(RST), .raw(SDA_IN[i]), .filt(sda_f), .glitch(sda_glitch)
      );

      // START/STOP need SCL high in both this and the previous cycle, so a
      // simultaneous SCL/SDA change yields no condition and no sample.
      assign start_det = scl_f & scl_q & sda_q & ~sda_f;
      assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
      assign sample    = scl_f & ~scl_q & (sda_f == sda_q);

      always_comb begin
         state_nxt  = state;
         bitcnt_nxt = bitcnt;
         shreg_nxt  = shreg;
         data_nxt   = data;
         first_nxt  = first;
         ack_nxt    = ack;
         bfirst_nxt = bfirst;
         start_nxt  = 1'b0;
         stop_nxt   = 1'b0;
         vld_nxt    = 1'b0;
         to_nxt     = 1'b0;
         to_cnt_nxt = '0;
         if (!EN[i]) begin
            state_nxt = ST_IDLE;
         end else if (start_det) begin
            state_nxt  = ST_DATA;
            bitcnt_nxt = '0;
            first_nxt  = 1'b1;
            start_nxt  = 1'b1;
         end else if (stop_det) begin
            state_nxt = ST_IDLE;
            stop_nxt  = 1'b1;
         end else if (state != ST_IDLE) begin
            if (!scl_f) begin
               if (to_cnt == TO_LAST) begin
                  state_nxt = ST_IDLE;
                  to_nxt    = 1'b1;
               end else begin
                  to_cnt_nxt = to_cnt + 1'b1;
               end
            end
            if (sample) begin
               if (state == ST_DATA) begin
                  shreg_nxt  = {shreg[6:0], sda_f};
                  bitcnt_nxt = bitcnt + 1'b1;
                  if (bitcnt == 4'd7) begin
                     state_nxt = ST_ACK;
                  end
               end else begin
                  data_nxt   = shreg;
                  ack_nxt    = (sda_f == ACK_LVL);
                  bfirst_nxt = first;
                  vld_nxt    = 1'b1;
                  first_nxt  = 1'b0;
                  bitcnt_nxt = '0;
                  state_nxt  = ST_DATA;
               end
            end
         end
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            state   <= ST_IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            data    <= '0;
            first   <= 1'b0;
            ack     <= 1'b0;
            bfirst  <= 1'b0;
            start_p <= 1'b0;
            stop_p  <= 1'b0;
            vld     <= 1'b0;
            to_p    <= 1'b0;
            to_cnt  <= '0;
            scl_q   <= BUS_IDLE;
            sda_q   <= BUS_IDLE;
         end else begin
            state   <= state_nxt;
            bitcnt  <= bitcnt_nxt;
            shreg   <= shreg_nxt;
            data    <= data_nxt;
            first   <= first_nxt;
            ack     <= ack_nxt;
            bfirst  <= bfirst_nxt;
            start_p <= start_nxt;
            stop_p  <= stop_nxt;
            vld     <= vld_nxt;
            to_p    <= to_nxt;
            to_cnt  <= to_cnt_nxt;
            scl_q   <= scl_f;
            sda_q   <= sda_f;
         end
      end

      // Gating with EN keeps pulses and BUSY quiet in the very cycle the channel is disabled.
      assign SCL_F[i]          = scl_f;
      assign SDA_F[i]          = sda_f;
      assign START_P[i]        = EN[i] & start_p;
      assign STOP_P[i]         = EN[i] & stop_p;
      assign BYTE_VLD[i]       = EN[i] & vld;
      assign TIMEOUT_P[i]      = EN[i] & to_p;
      assign GLITCH_P[i]       = EN[i] & (scl_glitch | sda_glitch);
      assign BUSY[i]           = EN[i] & (state != ST_IDLE);
      assign BYTE_DATA[8*i +: 8] = data;
      assign BYTE_ACK[i]       = ack;
      assign BYTE_FIRST[i]     = bfirst;
   end

endmodule

// File: tb/tb_i2c_bus_mon.sv
// Bench for i2c_bus_mon: drives I2C transfers on two channels and checks captured
// bytes, conditions, glitches, timeouts, reset and enable behaviour against expectations.
module tb_i2c_bus_mon;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  EN;
   logic        scl_drv [2];
   logic        sda_drv [2];
   logic [1:0]  SCL_IN, SDA_IN;
   logic [1:0]  SCL_F, SDA_F, START_P, STOP_P, BYTE_VLD, BYTE_ACK, BYTE_FIRST;
   logic [1:0]  GLITCH_P, TIMEOUT_P, BUSY;
   logic [15:0] BYTE_DATA;

   typedef struct packed {logic [7:0] d; logic a; logic f;} exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_fail = 0;

   int cyc = 0;
   int n_start[2], n_stop[2], n_glitch[2], n_to[2], obs_n[2];
   int n_sdaf_fall[2], n_sclf_rise[2], n_sdaf_rise[2];
   int sdaf_fall_cyc[2], sclf_fall_cyc[2], stop_cyc[2], to_cyc[2], busy_fall_cyc[2];
   logic [7:0] obs_d [2][64];
   logic       obs_a [2][64];
   logic       obs_f [2][64];
   logic [1:0] prev_busy, prev_sclf, prev_sdaf;

   assign SCL_IN = {scl_drv[1], scl_drv[0]};
   assign SDA_IN = {sda_drv[1], sda_drv[0]};

   i2c_bus_mon #(.NCH(2), .FILT_LEN(3), .CNT_W(4), .TO_CYC(16), .TO_W(5)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .SCL_IN(SCL_IN), .SDA_IN(SDA_IN),
      .SCL_F(SCL_F), .SDA_F(SDA_F), .START_P(START_P), .STOP_P(STOP_P),
      .BYTE_VLD(BYTE_VLD), .BYTE_DATA(BYTE_DATA), .BYTE_ACK(BYTE_ACK),
      .BYTE_FIRST(BYTE_FIRST), .GLITCH_P(GLITCH_P), .TIMEOUT_P(TIMEOUT_P), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Event recorder: counts and time-stamps what the DUT reports on each channel.
   always @(negedge CLK) begin
      for (int c = 0; c < 2; c++) begin
         if (START_P[c] === 1'b1) n_start[c] <= n_start[c] + 1;
         if (STOP_P[c] === 1'b1) begin
            n_stop[c]   <= n_stop[c] + 1;
            stop_cyc[c] <= cyc;
         end
         if (GLITCH_P[c] === 1'b1) n_glitch[c] <= n_glitch[c] + 1;
         if (TIMEOUT_P[c] === 1'b1) begin
            n_to[c]   <= n_to[c] + 1;
            to_cyc[c] <= cyc;
         end
         if (BYTE_VLD[c] === 1'b1 && obs_n[c] < 64) begin
            obs_d[c][obs_n[c]] <= BYTE_DATA[8*c +: 8];
            obs_a[c][obs_n[c]] <= BYTE_ACK[c];
            obs_f[c][obs_n[c]] <= BYTE_FIRST[c];
            obs_n[c]           <= obs_n[c] + 1;
         end
         if (prev_busy[c] === 1'b1 && BUSY[c] === 1'b0) busy_fall_cyc[c] <= cyc;
         if (prev_sdaf[c] === 1'b1 && SDA_F[c] === 1'b0) begin
            sdaf_fall_cyc[c] <= cyc;
            n_sdaf_fall[c]   <= n_sdaf_fall[c] + 1;
         end
         if (prev_sdaf[c] === 1'b0 && SDA_F[c] === 1'b1) n_sdaf_rise[c] <= n_sdaf_rise[c] + 1;
         if (prev_sclf[c] === 1'b1 && SCL_F[c] === 1'b0) sclf_fall_cyc[c] <= cyc;
         if (prev_sclf[c] === 1'b0 && SCL_F[c] === 1'b1) n_sclf_rise[c] <= n_sclf_rise[c] + 1;
      end
      prev_busy <= BUSY;
      prev_sclf <= SCL_F;
      prev_sdaf <= SDA_F;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_start(input int ch, input int h);
      sda_drv[ch] = 1'b1; tick(h);
      scl_drv[ch] = 1'b1; tick(h);
      sda_drv[ch] = 1'b0; tick(h);
      scl_drv[ch] = 1'b0; tick(h);
   endtask

   task automatic send_bit(input int ch, input logic b, input int h);
      sda_drv[ch] = b;    tick(h);
      scl_drv[ch] = 1'b1; tick(2 * h);
      scl_drv[ch] = 1'b0; tick(h);
   endtask

   task automatic send_byte(input int ch, input logic [7:0] d, input int h);
      for (int k = 7; k >= 0; k--) send_bit(ch, d[k], h);
   endtask

   task automatic do_stop(input int ch, input int h);
      sda_drv[ch] = 1'b0; tick(h);
      scl_drv[ch] = 1'b1; tick(h);
      sda_drv[ch] = 1'b1; tick(h);
   endtask

   // Random transfer of nb bytes; each byte's expected record goes onto exp_q.
   task automatic rand_xfer(input int ch, input int nb, input int h);
      exp_t e;
      do_start(ch, h);
      for (int j = 0; j < nb; j++) begin
         e.d = 8'($urandom_range(0, 255));
         e.a = 1'($urandom_range(0, 1));
         e.f = (j == 0);
         exp_q.push_back(e);
         send_byte(ch, e.d, h);
         send_bit(ch, ~e.a, h);
      end
      do_stop(ch, h);
   endtask

   task automatic test_reset();
      RST = 1'b1; EN = 2'b11;
      scl_drv[0] = 1'b1; scl_drv[1] = 1'b1; sda_drv[0] = 1'b1; sda_drv[1] = 1'b1;
      tick(4);
      n_cmp++; if ({SCL_F, SDA_F} !== 4'b1111) begin n_fail++; $display("FAIL rst_lines: got %b want 1111", {SCL_F, SDA_F}); end
      n_cmp++; if ({START_P, STOP_P, BYTE_VLD, GLITCH_P, TIMEOUT_P, BUSY} !== 12'b0) begin n_fail++; $display("FAIL rst_pulses: got %b want 0", {START_P, STOP_P, BYTE_VLD, GLITCH_P, TIMEOUT_P, BUSY}); end
      n_cmp++; if ({BYTE_DATA, BYTE_ACK, BYTE_FIRST} !== 20'h0) begin n_fail++; $display("FAIL rst_byte: got %h want 0", {BYTE_DATA, BYTE_ACK, BYTE_FIRST}); end
      RST = 1'b0;
      tick(8);
   endtask

   task automatic test_glitch();
      int g0, s0, f0, p0, c0;
      g0 = n_glitch[0]; s0 = n_start[0]; f0 = n_sdaf_fall[0];
      sda_drv[0] = 1'b0; tick(2); sda_drv[0] = 1'b1; tick(12);
      n_cmp++; if (n_glitch[0] - g0 !== 1) begin n_fail++; $display("FAIL glitch_cnt: got %0d want 1", n_glitch[0] - g0); end
      n_cmp++; if (n_sdaf_fall[0] - f0 !== 0 || SDA_F[0] !== 1'b1) begin n_fail++; $display("FAIL glitch_sdaf: falls %0d level %b want 0 1", n_sdaf_fall[0] - f0, SDA_F[0]); end
      n_cmp++; if (n_start[0] - s0 !== 0) begin n_fail++; $display("FAIL glitch_start: got %0d want 0", n_start[0] - s0); end
      g0 = n_glitch[0]; s0 = n_start[0]; p0 = n_stop[0];
      c0 = cyc;
      sda_drv[0] = 1'b0; tick(4); sda_drv[0] = 1'b1; tick(12);
      n_cmp++; if (sdaf_fall_cyc[0] - c0 !== 5) begin n_fail++; $display("FAIL pass_latency: got %0d want 5", sdaf_fall_cyc[0] - c0); end
      n_cmp++; if (n_start[0] - s0 !== 1) begin n_fail++; $display("FAIL pass_start: got %0d want 1", n_start[0] - s0); end
      n_cmp++; if (n_stop[0] - p0 !== 1 || n_glitch[0] - g0 !== 0) begin n_fail++; $display("FAIL pass_stop_glitch: stop %0d glitch %0d want 1 0", n_stop[0] - p0, n_glitch[0] - g0); end
   endtask

   task automatic test_byte_capture();
      int b, p0;
      b = obs_n[0]; p0 = n_stop[0];
      do_start(0, 4);
      send_byte(0, 8'hA4, 4); send_bit(0, 1'b0, 4);
      send_byte(0, 8'h5A, 4); send_bit(0, 1'b1, 4);
      do_stop(0, 4);
      tick(8);
      n_cmp++; if (obs_n[0] - b !== 2) begin n_fail++; $display("FAIL cap_count: got %0d want 2", obs_n[0] - b); end
      n_cmp++; if ({obs_d[0][b], obs_f[0][b], obs_a[0][b]} !== {8'hA4, 1'b1, 1'b1}) begin n_fail++; $display("FAIL cap_byte1: got %h %b %b want a4 1 1", obs_d[0][b], obs_f[0][b], obs_a[0][b]); end
      n_cmp++; if ({obs_d[0][b+1], obs_f[0][b+1], obs_a[0][b+1]} !== {8'h5A, 1'b0, 1'b0}) begin n_fail++; $display("FAIL cap_byte2: got %h %b %b want 5a 0 0", obs_d[0][b+1], obs_f[0][b+1], obs_a[0][b+1]); end
      n_cmp++; if (n_stop[0] - p0 !== 1) begin n_fail++; $display("FAIL cap_stop: got %0d want 1", n_stop[0] - p0); end
      n_cmp++; if (busy_fall_cyc[0] !== stop_cyc[0] || BUSY[0] !== 1'b0) begin n_fail++; $display("FAIL cap_busy_fall: got %0d want %0d", busy_fall_cyc[0], stop_cyc[0]); end
      n_cmp++; if ({BYTE_DATA[7:0], BYTE_ACK[0], BYTE_FIRST[0]} !== {8'h5A, 1'b0, 1'b0}) begin n_fail++; $display("FAIL cap_hold: got %h want 5a 0 0", {BYTE_DATA[7:0], BYTE_ACK[0], BYTE_FIRST[0]}); end
   endtask

   task automatic test_reset_mid();
      int b;
      b = obs_n[0];
      do_start(0, 4);
      for (int k = 0; k < 4; k++) send_bit(0, 1'($urandom_range(0, 1)), 4);
      RST = 1'b1; tick(1);
      n_cmp++; if ({SCL_F[0], SDA_F[0], BUSY[0]} !== 3'b110) begin n_fail++; $display("FAIL rmid_state: got %b want 110", {SCL_F[0], SDA_F[0], BUSY[0]}); end
      n_cmp++; if ({START_P, STOP_P, BYTE_VLD, GLITCH_P, TIMEOUT_P} !== 10'b0) begin n_fail++; $display("FAIL rmid_pulses: got %b want 0", {START_P, STOP_P, BYTE_VLD, GLITCH_P, TIMEOUT_P}); end
      n_cmp++; if ({BYTE_DATA, BYTE_ACK, BYTE_FIRST} !== 20'h0) begin n_fail++; $display("FAIL rmid_byte: got %h want 0", {BYTE_DATA, BYTE_ACK, BYTE_FIRST}); end
      scl_drv[0] = 1'b1; sda_drv[0] = 1'b1;
      tick(4); RST = 1'b0; tick(10);
      n_cmp++; if (obs_n[0] - b !== 0 || BUSY[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_novld: got %0d busy %b want 0 0", obs_n[0] - b, BUSY[0]); end
      exp_q.delete();
      rand_xfer(0, 1, 4);
      tick(6);
      n_cmp++; if (obs_n[0] - b !== 1 || {obs_d[0][b], obs_a[0][b], obs_f[0][b]} !== exp_q[0]) begin n_fail++; $display("FAIL rmid_after: got %0d %h want 1 %h", obs_n[0] - b, {obs_d[0][b], obs_a[0][b], obs_f[0][b]}, exp_q[0]); end
   endtask

   task automatic test_repeated_start();
      int b, s0;
      logic [7:0] a0, d2;
      a0 = 8'($urandom_range(0, 255)); d2 = 8'($urandom_range(0, 255));
      b = obs_n[0]; s0 = n_start[0];
      do_start(0, 4);
      send_byte(0, a0, 4); send_bit(0, 1'b0, 4);
      for (int k = 0; k < 3; k++) send_bit(0, 1'($urandom_range(0, 1)), 4);
      do_start(0, 4);
      send_byte(0, d2, 4); send_bit(0, 1'b0, 4);
      do_stop(0, 4);
      tick(8);
      n_cmp++; if (n_start[0] - s0 !== 2) begin n_fail++; $display("FAIL rs_starts: got %0d want 2", n_start[0] - s0); end
      n_cmp++; if (obs_n[0] - b !== 2) begin n_fail++; $display("FAIL rs_count: got %0d want 2", obs_n[0] - b); end
      n_cmp++; if ({obs_d[0][b+1], obs_f[0][b+1], obs_d[0][b], obs_f[0][b]} !== {d2, 1'b1, a0, 1'b1}) begin n_fail++; $display("FAIL rs_bytes: got %h %b %h %b want %h 1 %h 1", obs_d[0][b+1], obs_f[0][b+1], obs_d[0][b], obs_f[0][b], d2, a0); end
   endtask

   task automatic test_timeout();
      int b, t0, d;
      b = obs_n[0]; t0 = n_to[0];
      do_start(0, 4);
      tick(30);
      d = to_cyc[0] - sclf_fall_cyc[0];
      n_cmp++; if (n_to[0] - t0 !== 1) begin n_fail++; $display("FAIL to_count: got %0d want 1", n_to[0] - t0); end
      n_cmp++; if (!(d == 15 || d == 16)) begin n_fail++; $display("FAIL to_delay: got %0d want 15..16", d); end
      n_cmp++; if (BUSY[0] !== 1'b0 || busy_fall_cyc[0] !== to_cyc[0]) begin n_fail++; $display("FAIL to_busy: got %b at %0d want 0 at %0d", BUSY[0], busy_fall_cyc[0], to_cyc[0]); end
      for (int k = 0; k < 9; k++) send_bit(0, 1'($urandom_range(0, 1)), 4);
      do_stop(0, 4);
      tick(8);
      n_cmp++; if (obs_n[0] - b !== 0 || n_to[0] - t0 !== 1) begin n_fail++; $display("FAIL to_nocap: got %0d bytes %0d timeouts want 0 1", obs_n[0] - b, n_to[0] - t0); end
   endtask

   task automatic test_random_bytes();
      int b;
      exp_q.delete();
      b = obs_n[0];
      for (int t = 0; t < 4; t++) rand_xfer(0, $urandom_range(1, 3), $urandom_range(4, 6));
      tick(8);
      n_cmp++; if (obs_n[0] - b !== exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs_n[0] - b, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if ({obs_d[0][b+i], obs_a[0][b+i], obs_f[0][b+i]} !== exp_q[i]) begin
            n_fail++; $display("FAIL rnd_byte%0d: got %h want %h", i, {obs_d[0][b+i], obs_a[0][b+i], obs_f[0][b+i]}, exp_q[i]);
         end
      end
   endtask

   task automatic test_multichannel();
      int b0, b1, p1, r1, sr1, drop_cyc, exp_sr;
      logic [7:0] d1;
      logic lvl;
      logic nxt [7];
      d1 = 8'hC3;
      b0 = obs_n[0]; b1 = obs_n[1]; p1 = n_stop[1];
      fork
         begin
            do_start(0, 4); send_byte(0, 8'h3C, 4); send_bit(0, 1'b0, 4); do_stop(0, 4);
         end
         begin
            do_start(1, 4);
            for (int k = 7; k >= 4; k--) send_bit(1, d1[k], 4);
            EN[1] = 1'b0; drop_cyc = cyc;
            r1 = n_sclf_rise[1]; sr1 = n_sdaf_rise[1];
            for (int k = 3; k >= 0; k--) send_bit(1, d1[k], 4);
            send_bit(1, 1'b0, 4);
            do_stop(1, 4);
         end
      join
      tick(10);
      lvl = d1[4];
      nxt = '{d1[3], d1[2], d1[1], d1[0], 1'b0, 1'b0, 1'b1};
      exp_sr = 0;
      for (int k = 0; k < 7; k++) begin
         if (!lvl && nxt[k]) exp_sr++;
         lvl = nxt[k];
      end
      n_cmp++; if (obs_n[0] - b0 !== 1 || {obs_d[0][b0], obs_f[0][b0], obs_a[0][b0]} !== {8'h3C, 1'b1, 1'b1}) begin n_fail++; $display("FAIL mc_ch0: got %0d %h want 1 3c11", obs_n[0] - b0, {obs_d[0][b0], obs_f[0][b0], obs_a[0][b0]}); end
      n_cmp++; if (BYTE_DATA[7:0] !== 8'h3C) begin n_fail++; $display("FAIL mc_ch0_data: got %h want 3c", BYTE_DATA[7:0]); end
      n_cmp++; if (obs_n[1] - b1 !== 0 || n_stop[1] - p1 !== 0) begin n_fail++; $display("FAIL mc_ch1_quiet: got %0d bytes %0d stops want 0 0", obs_n[1] - b1, n_stop[1] - p1); end
      n_cmp++; if (BUSY[1] !== 1'b0 || busy_fall_cyc[1] !== drop_cyc) begin n_fail++; $display("FAIL mc_ch1_busy: got %b fall %0d want 0 fall %0d", BUSY[1], busy_fall_cyc[1], drop_cyc); end
      n_cmp++; if (n_sclf_rise[1] - r1 !== 6 || n_sdaf_rise[1] - sr1 !== exp_sr) begin n_fail++; $display("FAIL mc_ch1_track: got scl %0d sda %0d want 6 %0d", n_sclf_rise[1] - r1, n_sdaf_rise[1] - sr1, exp_sr); end
      EN[1] = 1'b1; tick(4);
      exp_q.delete();
      b1 = obs_n[1];
      rand_xfer(1, 1, 5);
      tick(8);
      n_cmp++; if (obs_n[1] - b1 !== 1 || {obs_d[1][b1], obs_a[1][b1], obs_f[1][b1]} !== exp_q[0]) begin n_fail++; $display("FAIL mc_ch1_reen: got %0d %h want 1 %h", obs_n[1] - b1, {obs_d[1][b1], obs_a[1][b1], obs_f[1][b1]}, exp_q[0]); end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_byte_capture();
      test_reset_mid();
      test_repeated_start();
      test_timeout();
      test_random_bytes();
      test_multichannel();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
